// File: rtl/numero_pkg.sv
// numero_pkg -- shared types, widths and decode equations for the numero_scan
// display driver.
//   state_e        : FSM states IDLE / LOAD / SCAN
//   SEG_W, CODE_W  : pattern and code widths
//   numero_decode  : raw 4-bit code -> 5-line pattern {d5,d4,d3,d2,d1}
package numero_pkg;

  localparam int SEG_W  = 5;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN
  } state_e;

  // Code bits are A(MSB) B C D(LSB). This function applies no blanking;
  // invalid-code handling lives in the decode sub-module.
  function automatic logic [SEG_W-1:0] numero_decode(input logic [CODE_W-1:0] code);
    logic a, b, c, d;
    logic d5, d4, d3, d2, d1;
    {a, b, c, d} = code;
    d5 = (b & ~c) | (~a & ~c & d) | (~b & c);
    d4 = (b & ~c) | (~b & c) | (c & ~d);
    d3 = b | (c & d);
    d2 = b | (a & ~c & ~d);
    d1 = a | (b & d) | (b & c);
    return {d5, d4, d3, d2, d1};
  endfunction

endpackage

// File: rtl/numero_scan_decode.sv
// numero_decode -- combinational code-to-pattern decoder, one per numero_scan.
// Optional feature macro: NUMERO_BLANK_EN (codes 1010..1111 blank and flag).
//   code_i    : 4-bit code, A(MSB) B C D(LSB)
//   seg_o     : {d5,d4,d3,d2,d1} pattern
//   invalid_o : high when the code was blanked as invalid (0 if feature off)
module numero_decode
  import numero_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o,
  output logic              invalid_o
);

`ifdef NUMERO_BLANK_EN
  assign invalid_o = (code_i >= CODE_W'(10));
  assign seg_o     = invalid_o ? '0 : numero_pkg::numero_decode(code_i);
`else
  assign invalid_o = 1'b0;
  assign seg_o     = numero_pkg::numero_decode(code_i);
`endif

endmodule

// File: rtl/numero_scan.sv
// numero_scan -- captures CHANNELS 4-bit codes on a rising edge of ready,
// decodes them one per clock into a pattern buffer, then time-multiplexes
// the display, holding each digit for SCAN_DIV clocks.
// Optional feature macro: NUMERO_BLANK_EN (blank codes 1010..1111, sticky err).
//   clock   : system clock, rising edge
//   reset   : asynchronous active-low reset
//   code_in : channel k code at [4k+3:4k]
//   ready   : load request; a rising edge starts a capture
//   clear   : synchronous clear to IDLE, wins over a load
//   ack     : one-cycle pulse when a load completes
//   seg     : pattern of the active digit
//   dig     : one-hot active digit, all-zero when blank
//   err     : sticky invalid-code flag
module numero_scan
  import numero_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CODE_W*CHANNELS-1:0] code_in,
  input  logic                       ready,
  input  logic                       clear,
  output logic                       ack,
  output logic [SEG_W-1:0]           seg,
  output logic [CHANNELS-1:0]        dig,
  output logic                       err
);

  localparam int K_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(CHANNELS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e                     state_q;
  logic                       ready_q;
  logic [CODE_W*CHANNELS-1:0] shadow_q;
  logic [SEG_W-1:0]           pattern_q [CHANNELS];
  logic [K_W-1:0]             k_q, idx_q, idx_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [SEG_W-1:0]           seg_q;
  logic [CHANNELS-1:0]        dig_q;
  logic                       ack_q, err_q;

  logic                       load_ev;
  logic [SEG_W-1:0]           dec_seg;
  logic                       dec_invalid;

  assign load_ev = ready & ~ready_q;

  numero_decode u_decode (
    .code_i    (shadow_q[k_q*CODE_W +: CODE_W]),
    .seg_o     (dec_seg),
    .invalid_o (dec_invalid)
  );

  // Scan position after this clock: div wraps at SCAN_DIV-1 and steps idx.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == K_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      shadow_q <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      seg_q    <= '0;
      dig_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      // NOTE: the pattern buffer is a small register array that must read
      // as zero after reset, so it is reset explicitly (not a RAM macro).
      for (int i = 0; i < CHANNELS; i++) pattern_q[i] <= '0;
    end else begin
      ready_q <= ready;
      ack_q   <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        k_q     <= '0;
        idx_q   <= '0;
        div_q   <= '0;
        seg_q   <= '0;
        dig_q   <= '0;
        err_q   <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) pattern_q[i] <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_ev) begin
              shadow_q <= code_in;
              k_q      <= '0;
              state_q  <= LOAD;
            end
          end
          LOAD: begin
            // seg/dig hold here, so the old display stays up until done.
            pattern_q[k_q] <= dec_seg;
            if (dec_invalid) err_q <= 1'b1;
            if (k_q == K_LAST) begin
              ack_q   <= 1'b1;
              state_q <= SCAN;
              idx_q   <= '0;
              div_q   <= '0;
              // Entry 0 is only being written this same clock when CHANNELS=1.
              seg_q   <= (k_q == '0) ? dec_seg : pattern_q[0];
              dig_q   <= CHANNELS'(1);
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
          SCAN: begin
            if (load_ev) begin
              shadow_q <= code_in;
              k_q      <= '0;
              state_q  <= LOAD;
            end else begin
              div_q <= div_d;
              idx_q <= idx_d;
              seg_q <= pattern_q[idx_d];
              dig_q <= CHANNELS'(1) << idx_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ack = ack_q;
  assign seg = seg_q;
  assign dig = dig_q;
  assign err = err_q;

endmodule

// File: tb/tb_numero_scan.sv
// tb_numero_scan -- directed self-checking bench for numero_scan.
// Main instance: CHANNELS=4, SCAN_DIV=3. Second instance: CHANNELS=1, SCAN_DIV=1.
// Expected values for code 1010 follow NUMERO_BLANK_EN.
module tb_numero_scan;

  logic        clock = 1'b0;
  logic        clk_run = 1'b0;
  logic        reset;

  logic [15:0] code_in;
  logic        ready, clear;
  logic        ack, err;
  logic [4:0]  seg;
  logic [3:0]  dig;

  logic [3:0]  code1;
  logic        ready1, clear1;
  logic        ack1, err1;
  logic [4:0]  seg1;
  logic [0:0]  dig1;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef NUMERO_BLANK_EN
  localparam logic [4:0] EXP_1010 = 5'b00000;
  localparam logic       EXP_ERR  = 1'b1;
`else
  localparam logic [4:0] EXP_1010 = 5'b11001;
  localparam logic       EXP_ERR  = 1'b0;
`endif

  numero_scan #(.CHANNELS(4), .SCAN_DIV(3)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .code_in (code_in),
    .ready   (ready),
    .clear   (clear),
    .ack     (ack),
    .seg     (seg),
    .dig     (dig),
    .err     (err)
  );

  numero_scan #(.CHANNELS(1), .SCAN_DIV(1)) u_dut1 (
    .clock   (clock),
    .reset   (reset),
    .code_in (code1),
    .ready   (ready1),
    .clear   (clear1),
    .ack     (ack1),
    .seg     (seg1),
    .dig     (dig1),
    .err     (err1)
  );

  always #5 if (clk_run) clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One-clock ready pulse on the chosen instance, then count clocks until
  // ack (the edge that samples the pulse is clock 1). Bounded at 20.
  task automatic pulse_and_wait(input bit one, output int n);
    if (one) ready1 = 1'b1;
    else     ready  = 1'b1;
    tick;
    ready  = 1'b0;
    ready1 = 1'b0;
    n = 1;
    while (((one ? ack1 : ack) !== 1'b1) && n < 20) begin
      tick;
      n++;
    end
  endtask

  logic [4:0] pat_a [4];
  logic [4:0] pat_b [4];
  int n, acks;

  initial begin
    // ch0..ch3 for codes {ch3..ch0} = {1000,0011,0101,0000}
    pat_a = '{5'b00000, 5'b11111, 5'b11100, 5'b00011};
    // ch0..ch3 for codes {ch3..ch0} = {0001,0010,0100,0110}
    pat_b = '{5'b01111, 5'b11110, 5'b11000, 5'b10000};

    reset = 1'b0; code_in = '0; ready = 1'b0; clear = 1'b0;
    code1 = '0; ready1 = 1'b0; clear1 = 1'b0;

    // Reset with the clock idle
    #20;
    check("rst_seg", seg, 0);
    check("rst_dig", dig, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_seg1", seg1, 0);
    check("rst_dig1", dig1, 0);
    reset = 1'b1;
    #3;
    clk_run = 1'b1;
    tick; tick;
    check("idle_seg", seg, 0);
    check("idle_dig", dig, 0);

    // First load, one-cycle ready pulse
    code_in = {4'b1000, 4'b0011, 4'b0101, 4'b0000};
    pulse_and_wait(1'b0, n);
    check("ack_latency", n, 5);
    check("err_valid", err, 0);
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 3; c++) begin
          check("scan_seg", seg, pat_a[d]);
          check("scan_dig", dig, 32'(1 << d));
          check("ack_pulse", ack, (r == 0 && d == 0 && c == 0) ? 1 : 0);
          tick;
        end

    // ready held high: single load
    ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      acks += int'(ack);
    end
    check("held_acks", acks, 1);

    // Drop and raise again with new codes
    code_in = {4'b0001, 4'b0010, 4'b0100, 4'b0110};
    ready = 1'b0;
    tick;
    pulse_and_wait(1'b0, n);
    check("reload_latency", n, 5);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 3; c++) begin
        check("reload_seg", seg, pat_b[d]);
        check("reload_dig", dig, 32'(1 << d));
        tick;
      end

    // A ready edge during LOAD is ignored
    ready = 1'b1; tick;
    ready = 1'b0; tick;
    ready = 1'b1; tick;
    ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      acks += int'(ack);
    end
    check("load_edge_acks", acks, 1);

    // clear together with a ready edge
    ready = 1'b1; clear = 1'b1;
    tick;
    ready = 1'b0; clear = 1'b0;
    check("clr_seg", seg, 0);
    check("clr_dig", dig, 0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      acks += int'(ack);
    end
    check("clr_acks", acks, 0);
    check("clr_seg_late", seg, 0);
    check("clr_dig_late", dig, 0);

    // Code 1010 on ch0
    code_in = {4'b0000, 4'b0000, 4'b0000, 4'b1010};
    pulse_and_wait(1'b0, n);
    check("inv_latency", n, 5);
    check("inv_seg", seg, EXP_1010);
    check("inv_dig", dig, 1);
    check("inv_err", err, EXP_ERR);
    tick; tick; tick;
    check("inv_dig_next", dig, 2);
    check("inv_seg_next", seg, 0);
    check("inv_err_sticky", err, EXP_ERR);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("inv_err_clr", err, 0);
    check("inv_seg_clr", seg, 0);

    // Asynchronous reset mid-SCAN
    code_in = {4'b1000, 4'b0011, 4'b0101, 4'b0000};
    pulse_and_wait(1'b0, n);
    tick; tick; tick;
    check("pre_rst_dig", dig, 2);
    check("pre_rst_seg", seg, 5'b11111);
    #2;
    reset = 1'b0;
    #1;
    check("arst_seg", seg, 0);
    check("arst_dig", dig, 0);
    check("arst_ack", ack, 0);
    check("arst_err", err, 0);
    reset = 1'b1;
    tick;
    check("arst_idle_dig", dig, 0);

    // CHANNELS=1, SCAN_DIV=1
    code1 = 4'b0101;
    pulse_and_wait(1'b1, n);
    check("c1_latency", n, 2);
    check("c1_seg", seg1, 5'b11111);
    check("c1_dig", dig1, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("c1_dig_hold", dig1, 1);
      check("c1_seg_hold", seg1, 5'b11111);
      check("c1_ack_low", ack1, 0);
    end
    code1 = 4'b0011;
    tick;
    pulse_and_wait(1'b1, n);
    check("c1_reload_latency", n, 2);
    check("c1_reload_seg", seg1, 5'b11100);
    check("c1_reload_dig", dig1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/numero_scan.md
# numero_scan

Parametrised multi-digit successor of the single-digit code decoder. Captures CHANNELS 4-bit codes on a rising edge of `ready` and decodes each into a 5-line display pattern with the team's fixed equations. Drives a time-multiplexed display: one digit at a time, each held for SCAN_DIV clocks. Sits between the code source (switches/datapath) and the physical display pins.

## Interface
- CHANNELS, 4: number of digits, ≥1.
- SCAN_DIV, 1000: clocks each digit stays active, ≥1.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- code_in  in  4*CHANNELS  channel k code at [4k+3:4k]; bit order A(MSB) B C D(LSB).
- ready  in  1  load request, synchronous to clock; rising edge triggers capture.
- clear  in  1  synchronous clear, active-high.
- ack  out  1  one-cycle pulse when a load completes.
- seg  out  5  {d5,d4,d3,d2,d1} of the active digit.
- dig  out  CHANNELS  one-hot active-digit select, all-zero when blank.
- err  out  1  sticky invalid-code flag (macro-dependent).

## Operation
- Decode equations: d5=B~C|~A~C D|~B C; d4=B~C|~B C|C~D; d3=B|C D; d2=B|A~C~D; d1=A|B D|B C.
- Edge detect: registered `ready_q`; load event = `ready & ~ready_q`.
- FSM states IDLE, LOAD, SCAN.
- IDLE: seg=0, dig=0. Load event -> capture all of code_in into shadow register, k=0, go LOAD.
- LOAD: decodes channel k into pattern buffer entry k, one channel per clock, k++. After channel CHANNELS-1: pulse ack, go SCAN with idx=0, div=0. Load events during LOAD are ignored.
- SCAN: dig=one-hot(idx), seg=pattern[idx]. div counts 0..SCAN_DIV-1. At SCAN_DIV-1: div=0; idx wraps CHANNELS-1 -> 0. A load event re-enters LOAD. The display keeps showing the old buffer until the new load completes, then restarts at idx=0.
- clear: returns to IDLE, zeroes the pattern buffer, seg, dig and err. clear has priority over a simultaneous load event.
- Reset (asynchronous, mid-operation or any time): state=IDLE, ready_q=0, buffer=0, k=idx=div=0, seg=0, dig=0, ack=0, err=0.
- Counter widths: k and idx are $clog2(CHANNELS) with a minimum of 1; div is $clog2(SCAN_DIV) with a minimum of 1. When CHANNELS=1, dig is constant 1 in SCAN.

## Timing
- All outputs are registered.
- Load event sampled at edge t. LOAD runs for edges t+1..t+CHANNELS. ack is high for exactly the cycle after edge t+CHANNELS, and SCAN outputs appear in that same cycle.
- Load latency from the ready edge to the first new pattern: CHANNELS+1 clocks.
- `ready` held high produces one load only. It must return low for at least one clock before the next load.
- SCAN_DIV=1: digit advances every clock.

## Configuration
- NUMERO_BLANK_EN defined:
  - Codes 1010–1111 decode to 5'b00000.
  - err sets at the LOAD cycle that decodes such a code and stays set until clear or reset.
- Undefined:
  - All 16 codes use the equations.
  - err is tied 0.

## Structure
- Package `numero_pkg` holds:
  - state enum {IDLE, LOAD, SCAN};
  - SEG_W=5 and CODE_W=4 constants;
  - function `numero_decode(code) -> seg`.
- Sub-module `numero_decode` holds the combinational equations plus the blanking under the macro; there is one instance, used by LOAD.
- The top module holds the FSM, counters, edge detect and pattern buffer.

## Test plan
- Reset with clock idle, then release: seg=0, dig=0, ack=0, err=0. Assert reset mid-SCAN: all outputs zero immediately, without waiting for a clock.
- CHANNELS=4, SCAN_DIV=3, codes {ch3..ch0}={1000,0011,0101,0000}, one ready pulse:
  - ack rises 5 clocks after the ready edge.
  - Pattern sequence is ch0 5'b00000, ch1 5'b11111, ch2 5'b11100, ch3 5'b00011, three clocks each.
  - dig sequence is 0001, 0010, 0100, 1000, then wraps.
- Hold ready high for 20 clocks: exactly one ack. Drop ready and raise it again: a second ack after CHANNELS+1 clocks, and the display shows the new codes starting at dig=0001.
- Ready edge during LOAD: ignored; only one ack. clear together with a ready edge: FSM in IDLE, seg=0, no ack.
- Code 1010 on ch0:
  - With NUMERO_BLANK_EN: seg=00000 on ch0, err=1 until clear.
  - Without: seg=11001, err=0.
- CHANNELS=1, SCAN_DIV=1: dig constant 1 in SCAN; seg holds the ch0 pattern; load latency is 2 clocks.
